// File: rtl/flash_cmd_seq.sv
// Turns host READ/PROGRAM/ERASE/STATUS requests into Intel/CFI NOR byte-command sequences, one bridge op at a time.
// Latency: each bus op costs bridge latency + 1 cycles; backpressure: cmd_ready only in IDLE, br_req held until br_done.
module flash_cmd_seq #(
    parameter int ADDR_W   = 8,
    parameter int POLL_MAX = 1024
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    input  logic [1:0]        cmd,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_wdata,
    output logic [7:0]        rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] br_addr,
    output logic [7:0]        br_wdata,
    output logic              br_rw,
    output logic              br_req,
    input  logic [7:0]        br_rdata,
    input  logic              br_done
);
    localparam int CNT_W = $clog2(POLL_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(POLL_MAX);

    localparam logic [1:0] CMD_READ = 2'b00;
    localparam logic [1:0] CMD_PROG = 2'b01;
    localparam logic [1:0] CMD_STAT = 2'b11;

    typedef enum logic [3:0] {
        IDLE, RA_CMD, RD, SETUP, DATA, POLL, CHECK, CLR, EXIT, STAT_CMD, FIN
    } state_t;

    state_t            state_q, state_d, iss_state;
    logic [1:0]        cmd_q, cmd_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [7:0]        br_wdata_q, br_wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [1:0]        err_q, err_d, chk_q, chk_d;
    logic              br_req_q, br_req_d, br_rw_q, br_rw_d;
    logic              rdv_q, rdv_d, done_q, done_d, rdy_q, rdy_d;
    logic              op_done, issue;

    function automatic logic is_bus(input state_t s);
        return (s == RA_CMD) || (s == RD) || (s == SETUP) || (s == DATA) ||
               (s == POLL) || (s == CLR) || (s == EXIT) || (s == STAT_CMD);
    endfunction

    // A br_done only counts while our request is actually outstanding.
    assign op_done = br_req_q & br_done;
    assign cnt_inc = (cnt_q < CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        br_wdata_d = br_wdata_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        chk_d      = chk_q;
        br_req_d   = br_req_q;
        br_rw_d    = br_rw_q;
        rdv_d      = 1'b0;
        done_d     = 1'b0;
        issue      = 1'b0;
        iss_state  = state_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && rdy_q) begin
                    cmd_d   = cmd;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    err_d   = 2'b00;
                    cnt_d   = '0;
                    case (cmd)
                        CMD_READ: state_d = RA_CMD;
                        CMD_STAT: state_d = STAT_CMD;
                        default:  state_d = SETUP;
                    endcase
                    issue     = 1'b1;
                    iss_state = state_d;
                end
            end
            RA_CMD:   if (op_done) state_d = RD;
            STAT_CMD: if (op_done) state_d = RD;
            RD: begin
                if (op_done) begin
                    rdata_d = br_rdata;
                    rdv_d   = 1'b1;
                    state_d = (cmd_q == CMD_STAT) ? EXIT : FIN;
                end
            end
            SETUP: if (op_done) state_d = DATA;
            DATA:  if (op_done) state_d = POLL;
            POLL: begin
                if (op_done) begin
                    cnt_d = cnt_inc;
                    if (br_rdata[7]) begin
                        state_d = CHECK;
                        if (br_rdata[3] | br_rdata[1])      chk_d = 2'b10;
                        else if (br_rdata[5] | br_rdata[4]) chk_d = 2'b01;
                        else                                chk_d = 2'b00;
                    end else if (cnt_inc == CNT_MAX) begin
                        err_d   = 2'b11;
                        state_d = CLR;
                    end
                end
            end
            CHECK: begin
                err_d   = chk_q;
                state_d = (chk_q == 2'b00) ? EXIT : CLR;
            end
            CLR:  if (op_done) state_d = EXIT;
            EXIT: if (op_done) state_d = FIN;
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The cycle after a completed op is the mandatory gap; the next op issues from here.
        if (!br_req_q && is_bus(state_q)) begin
            issue     = 1'b1;
            iss_state = state_q;
        end
        if (op_done) br_req_d = 1'b0;
        if (issue) begin
            br_req_d = 1'b1;
            br_rw_d  = (iss_state == RD) || (iss_state == POLL);
            case (iss_state)
                RA_CMD, EXIT: br_wdata_d = 8'hFF;
                SETUP:        br_wdata_d = (cmd_d == CMD_PROG) ? 8'h40 : 8'h20;
                DATA:         br_wdata_d = (cmd_d == CMD_PROG) ? wdata_d : 8'hD0;
                CLR:          br_wdata_d = 8'h50;
                STAT_CMD:     br_wdata_d = 8'h70;
                default:      br_wdata_d = br_wdata_q;
            endcase
        end

        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            cmd_q      <= 2'b00;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            br_wdata_q <= 8'h00;
            addr_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 2'b00;
            chk_q      <= 2'b00;
            br_req_q   <= 1'b0;
            br_rw_q    <= 1'b1;
            rdv_q      <= 1'b0;
            done_q     <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            br_wdata_q <= br_wdata_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            chk_q      <= chk_d;
            br_req_q   <= br_req_d;
            br_rw_q    <= br_rw_d;
            rdv_q      <= rdv_d;
            done_q     <= done_d;
            rdy_q      <= rdy_d;
        end
    end

    assign cmd_ready   = rdy_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdv_q;
    assign done        = done_q;
    assign err_code    = err_q;
    assign br_addr     = addr_q;
    assign br_wdata    = br_wdata_q;
    assign br_rw       = br_rw_q;
    assign br_req      = br_req_q;

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Bench for flash_cmd_seq: behavioural bridge with fixed latency, op scoreboard, table of host commands.
module tb_flash_cmd_seq;
    localparam int PMAX = 4;
    localparam int LAT  = 3;
    localparam logic [1:0] C_RD = 2'b00, C_PG = 2'b01, C_ER = 2'b10, C_ST = 2'b11;

    typedef struct packed {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
    } op_t;

    typedef struct {
        logic [1:0]  cmd;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [31:0] resp;
        int          nresp;
        logic [1:0]  exp_err;
        logic [7:0]  exp_rdata;
        int          exp_ops;
        int          exp_rdv;
        bit          hold;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cmd;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_addr, cmd_wdata, rdata;
    logic       rdata_valid, done;
    logic [1:0] err_code;
    logic [7:0] br_addr, br_wdata, br_rdata;
    logic       br_rw, br_req, br_done;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, op_total = 0, rdv_total = 0, ovl_total = 0;
    int last_brdone_cyc = 0, rdv_cyc = 0, done_cyc = 0;
    op_t        exp_q[$];
    logic [7:0] resp_q[$];
    logic [7:0] last_rd = 8'h00;
    vec_t       vt[10];

    always #5 clk = ~clk;

    flash_cmd_seq #(.ADDR_W(8), .POLL_MAX(PMAX)) dut (
        .CLK_50MHZ(clk), .RST(rst_n), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .done(done), .err_code(err_code), .br_addr(br_addr), .br_wdata(br_wdata), .br_rw(br_rw),
        .br_req(br_req), .br_rdata(br_rdata), .br_done(br_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (br_done) last_brdone_cyc = cyc;
        if (rdata_valid) begin rdv_cyc = cyc; rdv_total++; end
        if (done) done_cyc = cyc;
        if ((done || rdata_valid) && br_req) ovl_total++;
    end

    // Bridge: sees a request one edge after it rises, answers LAT cycles after it rose.
    initial begin
        op_t o, e;
        br_done  = 1'b0;
        br_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (br_req) begin
                o = '{rw: br_rw, addr: br_addr, wdata: br_wdata};
                op_total++;
                if (exp_q.size() == 0) begin
                    check("unexpected_op", 32'(o), 32'h1FFFF);
                end else begin
                    e = exp_q.pop_front();
                    if (e.rw) check("bus_op_rd", 32'({o.rw, o.addr}), 32'({e.rw, e.addr}));
                    else      check("bus_op_wr", 32'(o), 32'(e));
                end
                repeat (LAT - 1) begin @(posedge clk); #1; end
                if (br_req) check("op_hold", 32'({br_rw, br_addr, br_wdata}), 32'(o));
                br_rdata = 8'hEE;
                if (o.rw && resp_q.size() > 0) br_rdata = resp_q.pop_front();
                else if (o.rw) br_rdata = 8'h00;
                br_done = 1'b1;
                @(posedge clk); #1;
                br_done = 1'b0;
            end
        end
    end

    task automatic push_op(input logic rw, input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back('{rw: rw, addr: a, wdata: d});
    endtask

    // Expected bus-op sequence from the command and the status bytes the bridge will return.
    task automatic model_ops(input vec_t v);
        logic [7:0] sr;
        bit rdy, bad;
        rdy = 0;
        sr  = 8'h00;
        case (v.cmd)
            C_RD: begin push_op(0, v.addr, 8'hFF); push_op(1, v.addr, 8'h00); end
            C_ST: begin push_op(0, v.addr, 8'h70); push_op(1, v.addr, 8'h00); push_op(0, v.addr, 8'hFF); end
            default: begin
                push_op(0, v.addr, (v.cmd == C_PG) ? 8'h40 : 8'h20);
                push_op(0, v.addr, (v.cmd == C_PG) ? v.wdata : 8'hD0);
                for (int i = 0; i < PMAX && !rdy; i++) begin
                    push_op(1, v.addr, 8'h00);
                    sr = (i < v.nresp) ? v.resp[8*i +: 8] : 8'h00;
                    rdy = sr[7];
                end
                bad = !rdy || sr[5] || sr[4] || sr[3] || sr[1];
                if (bad) push_op(0, v.addr, 8'h50);
                push_op(0, v.addr, 8'hFF);
            end
        endcase
        for (int i = 0; i < v.nresp; i++) resp_q.push_back(v.resp[8*i +: 8]);
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        int t, rdv0, ops0, ovl0, rdy_busy;
        bit got;
        model_ops(v);
        rdv0 = rdv_total; ops0 = op_total; ovl0 = ovl_total; rdy_busy = 0;
        @(negedge clk);
        cmd = v.cmd; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        check($sformatf("accept_wait[%0d]", idx), 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        check($sformatf("req_after_accept[%0d]", idx), 32'({br_req, cmd_ready}), 32'b10);
        if (v.hold) begin cmd = C_RD; cmd_addr = 8'hEE; end
        else cmd_valid = 1'b0;
        got = 0; t = 0;
        while (!got && t < 400) begin
            @(negedge clk); t++;
            if (done) got = 1;
            else if (cmd_ready) rdy_busy++;
        end
        cmd_valid = 1'b0;
        #1;
        check($sformatf("done_seen[%0d]", idx), 32'(got), 32'd1);
        check($sformatf("err_code[%0d]", idx), 32'(err_code), 32'(v.exp_err));
        if (v.cmd == C_RD || v.cmd == C_ST) last_rd = v.exp_rdata;
        check($sformatf("rdata[%0d]", idx), 32'(rdata), 32'(last_rd));
        check($sformatf("rdv_count[%0d]", idx), 32'(rdv_total - rdv0), 32'(v.exp_rdv));
        check($sformatf("op_count[%0d]", idx), 32'(op_total - ops0), 32'(v.exp_ops));
        check($sformatf("ops_left[%0d]", idx), 32'(exp_q.size()), 32'd0);
        check($sformatf("ready_busy[%0d]", idx), 32'(rdy_busy), 32'd0);
        check($sformatf("overlap[%0d]", idx), 32'(ovl_total - ovl0), 32'd0);
        if (v.cmd == C_RD) begin
            check($sformatf("rdv_lat[%0d]", idx), 32'(rdv_cyc - last_brdone_cyc), 32'd1);
            check($sformatf("done_lat[%0d]", idx), 32'(done_cyc - rdv_cyc), 32'd1);
        end
        @(negedge clk);
        check($sformatf("done_pulse[%0d]", idx), 32'({done, rdata_valid}), 32'd0);
    endtask

    initial begin
        vec_t rv;
        int t, ops0;
        //            cmd   addr   wdata  resp          n  err    rdata  ops rdv hold
        vt[0] = '{C_RD, 8'h12, 8'h00, 32'h000000A5, 1, 2'b00, 8'hA5, 2, 1, 0};
        vt[1] = '{C_PG, 8'h40, 8'h3C, 32'h00800000, 3, 2'b00, 8'h00, 6, 0, 1};
        vt[2] = '{C_ER, 8'h80, 8'h00, 32'h000000A0, 1, 2'b01, 8'h00, 5, 0, 0};
        vt[3] = '{C_ST, 8'h07, 8'h00, 32'h00000088, 1, 2'b00, 8'h88, 3, 1, 0};
        vt[4] = '{C_PG, 8'h09, 8'h11, 32'h00000088, 1, 2'b10, 8'h00, 5, 0, 0};
        vt[5] = '{C_PG, 8'h33, 8'h55, 32'h00000000, 4, 2'b11, 8'h00, 8, 0, 0};
        vt[6] = '{C_PG, 8'h5A, 8'hC3, 32'h000000A8, 1, 2'b10, 8'h00, 5, 0, 0};
        vt[7] = '{C_ER, 8'h21, 8'h00, 32'h80000000, 4, 2'b00, 8'h00, 7, 0, 0};
        vt[8] = '{C_RD, 8'h00, 8'h00, 32'h0000003C, 1, 2'b00, 8'h3C, 2, 1, 0};
        vt[9] = '{C_ER, 8'hFF, 8'h00, 32'h0000B000, 2, 2'b01, 8'h00, 6, 0, 0};

        rst_n = 1'b0; cmd = 2'b00; cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 32'({cmd_ready, br_req, rdata_valid, done, br_rw}), 32'b00001);
        check("rst_data", 32'({rdata, br_addr, br_wdata, err_code}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 10; i++) run_cmd(vt[i], i);

        // Reset while the DATA write is outstanding.
        rv = '{C_PG, 8'h44, 8'h77, 32'h0, 0, 2'b00, 8'h00, 0, 0, 0};
        model_ops(rv);
        @(negedge clk);
        cmd = C_PG; cmd_addr = 8'h44; cmd_wdata = 8'h77; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        t = 0;
        while (!(br_req && !br_rw && br_wdata == 8'h77) && t < 100) begin @(negedge clk); t++; end
        check("reach_data", 32'({br_req, br_wdata}), 32'h177);
        #2 rst_n = 1'b0;
        #1 check("req_async_drop", 32'(br_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        resp_q.delete();
        ops0 = op_total;
        repeat (6) @(negedge clk);
        check("post_rst_idle", 32'({cmd_ready, br_req, done, err_code}), 32'b10000);
        check("post_rst_no_ops", 32'(op_total - ops0), 32'd0);
        last_rd = 8'h00;

        rv = '{C_RD, 8'h12, 8'h00, 32'h0000005A, 1, 2'b00, 8'h5A, 2, 1, 0};
        run_cmd(rv, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end
endmodule
